// File: rtl/window_stats_pkg.sv
// Shared types and default sizing for the window statistics blocks.
// Module parameters default to the values here; derived widths come from the helper.
package window_stats_pkg;

    typedef enum logic [1:0] {StIdle, StVar, StSqrt, StDone} state_t;

    localparam int unsigned WINDOW_HEIGHT_DEF = 24;
    localparam int unsigned WINDOW_WIDTH_DEF  = 24;
    localparam int unsigned W_SUM_DEF         = 28;
    localparam int unsigned W_SQSUM_DEF       = 36;
    localparam int unsigned W_VAR_DEF         = 46;
    localparam int unsigned W_STD_DEF         = 23;

    // Width that holds both N*sqsum and sum^2 without loss.
    function automatic int unsigned prod_width(input int unsigned n,
                                               input int unsigned w_sum,
                                               input int unsigned w_sqsum);
        int unsigned a;
        int unsigned b;
        a = w_sqsum + int'($clog2(n + 1));
        b = 2 * w_sum;
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned N      = WINDOW_HEIGHT_DEF * WINDOW_WIDTH_DEF;
    localparam int unsigned W_PROD = prod_width(N, W_SUM_DEF, W_SQSUM_DEF);
    localparam int unsigned W_CNT  = $clog2(W_STD_DEF + 1);

endpackage

// File: rtl/isqrt_seq.sv
// Iterative integer square root, restoring bit-pair method, one root bit per cycle.
// start loads the radicand; done pulses for one cycle once root is final.
module isqrt_seq #(
    parameter int unsigned W_IN  = 46,
    parameter int unsigned W_OUT = 23,
    parameter int unsigned W_CNT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_IN-1:0]  rad,
    output logic             busy,
    output logic             done,
    output logic [W_OUT-1:0] root
);

    logic [W_IN-1:0]    rad_q;
    logic [W_OUT+1:0]   rem_q, rem_d, rem_sh, trial;
    logic [W_OUT-1:0]   root_q, root_d;
    logic [W_CNT-1:0]   cnt_q;
    logic               busy_q, done_q;

    always_comb begin
        rem_sh = (rem_q << 2) | {{W_OUT{1'b0}}, rad_q[W_IN-1 -: 2]};
        trial  = {root_q, 2'b01};
        rem_d  = rem_sh;
        root_d = root_q << 1;
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = (root_q << 1) | {{(W_OUT-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                rad_q  <= rad;
                rem_q  <= '0;
                root_q <= '0;
                cnt_q  <= W_CNT'(W_OUT);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rad_q  <= rad_q << 2;
                rem_q  <= rem_d;
                root_q <= root_d;
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == W_CNT'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/window_stddev.sv
// Joins a window sum with its squared-window sum and returns floor(sqrt(N*sqsum - sum^2)),
// i.e. N*sigma, for scaling cascade feature thresholds.
module window_stddev
    import window_stats_pkg::*;
#(
    parameter int unsigned WINDOW_HEIGHT = WINDOW_HEIGHT_DEF,
    parameter int unsigned WINDOW_WIDTH  = WINDOW_WIDTH_DEF,
    parameter int unsigned W_SUM         = W_SUM_DEF,
    parameter int unsigned W_SQSUM       = W_SQSUM_DEF,
    parameter int unsigned W_VAR         = W_VAR_DEF,
    parameter int unsigned W_STD         = W_STD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sum_valid,
    output logic               sum_ready,
    input  logic [W_SUM-1:0]   sum_data,
    input  logic               sqsum_valid,
    output logic               sqsum_ready,
    input  logic [W_SQSUM-1:0] sqsum_data,
    output logic               stddev_valid,
    input  logic               stddev_ready,
    output logic [W_STD-1:0]   stddev_data
);

    localparam int unsigned NPIX  = WINDOW_HEIGHT * WINDOW_WIDTH;
    localparam int unsigned WPROD = prod_width(NPIX, W_SUM, W_SQSUM);
    localparam int unsigned WCNT  = $clog2(W_STD + 1);
    localparam logic [W_VAR-1:0] VAR_MAX = '1;

    state_t             state_q;
    logic [W_SUM-1:0]   sum_q;
    logic [W_SQSUM-1:0] sqsum_q;
    logic [W_STD-1:0]   data_q;
    logic               valid_q;

    logic               accept;
    logic [WPROD-1:0]   prod_p, prod_s, diff;
    logic [W_VAR-1:0]   var_d;
    logic               sq_start, sq_busy, sq_done;
    logic [W_STD-1:0]   sq_root;

    // Both sides are consumed together; a lone valid never sees ready.
    assign accept      = (state_q == StIdle) && sum_valid && sqsum_valid && rst_n;
    assign sum_ready   = accept;
    assign sqsum_ready = accept;

    always_comb begin
        prod_p = WPROD'(NPIX) * WPROD'(sqsum_q);
        prod_s = WPROD'(sum_q) * WPROD'(sum_q);
        diff   = prod_p - prod_s;
        if (prod_s > prod_p) begin
            var_d = '0;
        end else if (|diff[WPROD-1:W_VAR]) begin
            var_d = VAR_MAX;
        end else begin
            var_d = diff[W_VAR-1:0];
        end
    end

    assign sq_start = (state_q == StVar) && !sq_busy;

    isqrt_seq #(
        .W_IN  (W_VAR),
        .W_OUT (W_STD),
        .W_CNT (WCNT)
    ) u_isqrt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (sq_start),
        .rad   (var_d),
        .busy  (sq_busy),
        .done  (sq_done),
        .root  (sq_root)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sum_q   <= '0;
            sqsum_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sum_q   <= sum_data;
                        sqsum_q <= sqsum_data;
                        state_q <= StVar;
                    end
                end
                StVar:  state_q <= StSqrt;
                StSqrt: begin
                    if (sq_done) begin
                        data_q  <= sq_root;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (stddev_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stddev_valid = valid_q;
    assign stddev_data  = data_q;

endmodule

// File: tb/tb_window_stddev.sv
// Randomized and directed bench for window_stddev against a plain-arithmetic reference.
module tb_window_stddev;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sum_valid, sqsum_valid, stddev_ready;
    logic        sum_ready, sqsum_ready, stddev_valid;
    logic [27:0] sum_data;
    logic [35:0] sqsum_data;
    logic [22:0] stddev_data;

    int checks = 0;
    int fails  = 0;

    window_stddev dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sum_valid    (sum_valid),
        .sum_ready    (sum_ready),
        .sum_data     (sum_data),
        .sqsum_valid  (sqsum_valid),
        .sqsum_ready  (sqsum_ready),
        .sqsum_data   (sqsum_data),
        .stddev_valid (stddev_valid),
        .stddev_ready (stddev_ready),
        .stddev_data  (stddev_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // floor(sqrt(max(0, 576*q - s*s))) clamped to a 46-bit variance.
    function automatic logic [63:0] model(input longint unsigned s, input longint unsigned q);
        longint unsigned p, ss, v, r;
        p  = 64'd576 * q;
        ss = s * s;
        if (ss > p) return 64'd0;
        v = p - ss;
        if (v > 64'h3FFF_FFFF_FFFF) v = 64'h3FFF_FFFF_FFFF;
        r = longint'($rtoi($sqrt(real'(v))));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic send(input logic [27:0] s, input logic [35:0] q);
        logic acc;
        acc         = 1'b0;
        sum_data    = s;
        sqsum_data  = q;
        sum_valid   = 1'b1;
        sqsum_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sum_ready && sqsum_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        sum_valid   = 1'b0;
        sqsum_valid = 1'b0;
        sum_data    = 28'($urandom());
        sqsum_data  = 36'({$urandom(), $urandom()});
        check_eq("accept", {63'd0, acc}, 64'd1);
    endtask

    // Called at accept edge + 1; checks latency, data, hold stability and handshake.
    task automatic wait_result(input logic [63:0] exp, input int hold, input bit do_hs);
        int   lat;
        logic seen_ready, bad;
        lat        = 0;
        seen_ready = 1'b0;
        bad        = 1'b0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            seen_ready = seen_ready | sum_ready | sqsum_ready;
            if (stddev_valid) break;
        end
        check_eq("latency", 64'(lat), 64'd25);
        check_eq("data", 64'(stddev_data), exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            seen_ready = seen_ready | sum_ready | sqsum_ready;
            if (!stddev_valid || 64'(stddev_data) != exp) bad = 1'b1;
        end
        if (hold > 0) check_eq("hold_stable", {63'd0, bad}, 64'd0);
        check_eq("busy_no_ready", {63'd0, seen_ready}, 64'd0);
        if (do_hs) begin
            stddev_ready = 1'b1;
            @(posedge clk);
            #1;
            stddev_ready = 1'b0;
            check_eq("valid_drop", {63'd0, stddev_valid}, 64'd0);
        end
    endtask

    task automatic run_pair(input logic [27:0] s, input logic [35:0] q, input int hold);
        send(s, q);
        wait_result(model(s, q), hold, 1'b1);
    endtask

    initial begin
        logic [27:0] s;
        logic [35:0] q;
        logic        lone;
        rst_n        = 1'b0;
        sum_valid    = 1'b1;
        sqsum_valid  = 1'b1;
        stddev_ready = 1'b0;
        sum_data     = 28'd5;
        sqsum_data   = 36'd7;
        #23;
        check_eq("rst_sum_ready", {63'd0, sum_ready}, 64'd0);
        check_eq("rst_sqsum_ready", {63'd0, sqsum_ready}, 64'd0);
        check_eq("rst_valid", {63'd0, stddev_valid}, 64'd0);
        check_eq("rst_data", 64'(stddev_data), 64'd0);
        sum_valid   = 1'b0;
        sqsum_valid = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;

        run_pair(28'd0, 36'd1, 0);
        run_pair(28'd0, 36'd2, 0);
        run_pair(28'd57600, 36'd11520000, 0);
        run_pair(28'd57600, 36'd5760000, 0);
        run_pair(28'd10, 36'd0, 0);
        run_pair(28'd146880, 36'd37454400, 0);

        // Lone valids must never be consumed.
        lone = 1'b0;
        sum_valid = 1'b1;
        sum_data  = 28'd3;
        repeat (5) begin
            @(negedge clk);
            lone = lone | sum_ready | sqsum_ready;
        end
        sum_valid   = 1'b0;
        sqsum_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            lone = lone | sum_ready | sqsum_ready;
        end
        sqsum_valid = 1'b0;
        check_eq("lone_valid", {63'd0, lone}, 64'd0);
        @(posedge clk);
        #1;

        // Second pair queued behind a back-pressured first result.
        send(28'd0, 36'd2);
        sum_data    = 28'd1000;
        sqsum_data  = 36'd9000;
        sum_valid   = 1'b1;
        sqsum_valid = 1'b1;
        wait_result(model(28'd0, 36'd2), 10, 1'b1);
        send(28'd1000, 36'd9000);
        wait_result(model(28'd1000, 36'd9000), 0, 1'b1);

        // Reset while the root is being built, then a clean pair.
        send(28'd57600, 36'd11520000);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", {63'd0, stddev_valid}, 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_pair(28'd0, 36'd1, 0);

        // Reset while a result is held in DONE.
        send(28'd0, 36'd2);
        wait_result(model(28'd0, 36'd2), 2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_done_valid", {63'd0, stddev_valid}, 64'd0);
        check_eq("rst_done_data", 64'(stddev_data), 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Windows built from random pixels.
        for (int k = 0; k < 16; k++) begin
            int unsigned lo, hi, px;
            longint unsigned acc_s, acc_q;
            lo    = $urandom_range(0, 255);
            hi    = $urandom_range(lo, 255);
            acc_s = 0;
            acc_q = 0;
            for (int i = 0; i < 576; i++) begin
                px    = $urandom_range(lo, hi);
                acc_s = acc_s + px;
                acc_q = acc_q + px * px;
            end
            run_pair(28'(acc_s), 36'(acc_q), int'($urandom_range(0, 3)));
        end

        // Arbitrary operand pairs, including sum^2 > N*sqsum.
        for (int k = 0; k < 10; k++) begin
            s = 28'($urandom_range(0, 1 << 20));
            q = 36'({$urandom(), $urandom()});
            if (k % 3 == 0) q = 36'($urandom_range(0, 4096));
            run_pair(s, q, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
